// File: rtl/c0_uart_yukleyici.sv
// UART program loader for core c0: receives a framed image on rx_i, writes it
// word by word into instruction memory and keeps the core in reset until done.
module c0_uart_yukleyici #(
    parameter int BIT_SURESI = 434,
    parameter int ADR_W      = 12
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             rx_i,
    output logic             tx_o,
    output logic             bellek_yaz_o,
    output logic [ADR_W-1:0] bellek_adres_o,
    output logic [31:0]      bellek_veri_o,
    input  logic             bellek_hazir_i,
    output logic             cekirdek_rst_o,
    output logic             yukleme_bitti_o,
    output logic             yukleme_hata_o
);

    localparam int SAY_W = $clog2(BIT_SURESI);
    localparam int YARIM = BIT_SURESI / 2;
    localparam logic [9:0] TX_CERCEVE = {1'b1, 8'h5A, 1'b0};

    typedef enum logic [1:0] {R_BOS, R_BASLA, R_VERI, R_DUR} rx_durum_t;
    typedef enum logic [2:0] {BOSTA, SENKRON, UZUNLUK, VERI, ONAY, BITTI, HATA} durum_t;

    // ---- stage p0/p1: rx synchronizer
    logic rx_p0, rx_p1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_p0 <= 1'b1;
            rx_p1 <= 1'b1;
        end else begin
            rx_p0 <= rx_i;
            rx_p1 <= rx_p0;
        end
    end

    // ---- receiver: bit timer and byte assembly
    rx_durum_t        rx_durum, rx_durum_d;
    logic [SAY_W-1:0] rx_say;
    logic [2:0]       rx_bit;
    logic [7:0]       rx_kay;
    logic [7:0]       rx_bayt;
    logic             rx_vld;
    logic             rx_yarim, rx_tam;
    logic             bayt_tamam, cerceve_hata;

    assign rx_yarim = (rx_say == SAY_W'(YARIM - 1));
    assign rx_tam   = (rx_say == SAY_W'(BIT_SURESI - 1));

    always_comb begin
        rx_durum_d   = rx_durum;
        bayt_tamam   = 1'b0;
        cerceve_hata = 1'b0;
        case (rx_durum)
            R_BOS:   if (!rx_p1) rx_durum_d = R_BASLA;
            // a start bit that is high again at mid-bit was only a glitch
            R_BASLA: if (rx_yarim) rx_durum_d = rx_p1 ? R_BOS : R_VERI;
            R_VERI:  if (rx_tam && rx_bit == 3'd7) rx_durum_d = R_DUR;
            R_DUR: begin
                if (rx_tam) begin
                    rx_durum_d   = R_BOS;
                    bayt_tamam   = rx_p1;
                    cerceve_hata = !rx_p1;
                end
            end
            default: rx_durum_d = R_BOS;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_durum <= R_BOS;
            rx_say   <= '0;
            rx_bit   <= '0;
            rx_vld   <= 1'b0;
        end else begin
            rx_durum <= rx_durum_d;
            rx_vld   <= bayt_tamam;
            if (rx_durum == R_BOS || rx_durum_d != rx_durum || rx_tam)
                rx_say <= '0;
            else
                rx_say <= rx_say + SAY_W'(1);
            if (rx_durum == R_BASLA)
                rx_bit <= '0;
            else if (rx_durum == R_VERI && rx_tam)
                rx_bit <= rx_bit + 3'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rx_durum == R_VERI && rx_tam)
            rx_kay <= {rx_p1, rx_kay[7:1]};
        if (bayt_tamam)
            rx_bayt <= rx_kay;
    end

    // ---- loader FSM, write holding register and acknowledge transmitter
    durum_t           durum, durum_d;
    logic [1:0]       bayt_idx;
    logic [7:0]       uz_dusuk;
    logic [23:0]      kelime_sr;
    logic [15:0]      alinacak, kalan;
    logic [15:0]      uzunluk;
    logic [ADR_W-1:0] adr_say;
    logic [SAY_W-1:0] tx_say;
    logic [3:0]       tx_bit;
    logic             kabul, kelime_tamam, tasma, son_kabul, tx_tam, tx_son;

    assign uzunluk      = {rx_bayt, uz_dusuk};
    assign kabul        = bellek_yaz_o & bellek_hazir_i;
    assign kelime_tamam = (durum == VERI) & rx_vld & (bayt_idx == 2'd3) & (alinacak != 16'd0);
    // new word ready while the previous one is still unaccepted
    assign tasma        = kelime_tamam & bellek_yaz_o & ~bellek_hazir_i;
    assign son_kabul    = kabul & (kalan == 16'd1);
    assign tx_tam       = (tx_say == SAY_W'(BIT_SURESI - 1));
    assign tx_son       = tx_tam & (tx_bit == 4'd9);

    always_comb begin
        durum_d = durum;
        case (durum)
            BOSTA, SENKRON: if (rx_vld) durum_d = (rx_bayt == 8'hA5) ? UZUNLUK : SENKRON;
            UZUNLUK:        if (rx_vld && bayt_idx[0]) durum_d = (uzunluk == 16'd0) ? ONAY : VERI;
            VERI: begin
                if (tasma)          durum_d = HATA;
                else if (son_kabul) durum_d = ONAY;
            end
            ONAY:           if (tx_son) durum_d = BITTI;
            BITTI, HATA:    durum_d = durum;
            default:        durum_d = HATA;
        endcase
        if (cerceve_hata && durum != BITTI)
            durum_d = HATA;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            durum          <= BOSTA;
            bayt_idx       <= '0;
            alinacak       <= '0;
            kalan          <= '0;
            adr_say        <= '0;
            tx_say         <= '0;
            tx_bit         <= '0;
            bellek_yaz_o   <= 1'b0;
            bellek_adres_o <= '0;
            bellek_veri_o  <= '0;
        end else begin
            durum <= durum_d;
            if (durum == UZUNLUK && rx_vld) begin
                if (bayt_idx[0]) begin
                    bayt_idx <= '0;
                    alinacak <= uzunluk;
                    kalan    <= uzunluk;
                end else begin
                    bayt_idx <= 2'd1;
                end
            end else if (durum == VERI && rx_vld && alinacak != 16'd0) begin
                bayt_idx <= bayt_idx + 2'd1;
            end

            if (kelime_tamam && !tasma) begin
                bellek_yaz_o   <= 1'b1;
                bellek_adres_o <= adr_say;
                bellek_veri_o  <= {rx_bayt, kelime_sr};
                adr_say        <= adr_say + ADR_W'(1);
                alinacak       <= alinacak - 16'd1;
            end else if (kabul) begin
                bellek_yaz_o <= 1'b0;
            end
            if (kabul)
                kalan <= kalan - 16'd1;
            if (durum_d == HATA)
                bellek_yaz_o <= 1'b0;

            if (durum != ONAY) begin
                tx_say <= '0;
                tx_bit <= '0;
            end else if (tx_tam) begin
                tx_say <= '0;
                tx_bit <= tx_bit + 4'd1;
            end else begin
                tx_say <= tx_say + SAY_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (durum == UZUNLUK && rx_vld && !bayt_idx[0])
            uz_dusuk <= rx_bayt;
        if (durum == VERI && rx_vld && alinacak != 16'd0)
            kelime_sr <= {rx_bayt, kelime_sr[23:8]};
    end

    assign tx_o            = (durum == ONAY) ? TX_CERCEVE[tx_bit] : 1'b1;
    assign cekirdek_rst_o  = (durum != BITTI);
    assign yukleme_bitti_o = (durum == BITTI);
    assign yukleme_hata_o  = (durum == HATA);

endmodule
